// File: rtl/column_sum_sequencer_pkg.sv
// Shared coprocessor definitions: sequencer/adder state encodings, FP constants
// and the column-major cell-index helper.
package column_sum_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    ACK  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    ADD_IDLE = 2'd0,
    ADD_RUN  = 2'd1,
    ADD_OUT  = 2'd2
  } add_state_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  // Flat cell number of (row, col) in a column-major size x size matrix.
  function automatic int cell_index(input int r, input int c, input int size);
    return c * size + r;
  endfunction

endpackage

// File: rtl/column_sum_sequencer_if.sv
// Request/result bundle between the matrix operand register, the column-sum
// sequencer and its result consumer.
interface column_sum_sequencer_if #(
  parameter int size       = 4,
  parameter int cell_width = 32,
  parameter int width      = cell_width * size * size
);
  logic [width-1:0]           in_matrix;
  logic                       in_ready;
  logic                       out_ack;
  logic                       out_busy;
  logic                       out_ready;
  logic [cell_width*size-1:0] out_sums;

  modport master (
    output in_matrix, in_ready, out_ack,
    input  out_busy, out_ready, out_sums
  );

  modport slave (
    input  in_matrix, in_ready, out_ack,
    output out_busy, out_ready, out_sums
  );
endinterface

// File: rtl/column_sum_sequencer_adder.sv
// column_adder: sums one column of single-precision cells sequentially, one
// IEEE-754 addition (round-to-nearest-even) per clock, with a ready/ack result.
module column_adder
  import column_sum_sequencer_pkg::*;
#(
  parameter int size       = 4,
  parameter int cell_width = 32
) (
  input  logic                       in_clk,
  input  logic                       in_reset,
  input  logic                       c_ready,
  input  logic [cell_width*size-1:0] c_col,
  output logic                       c_out_ready,
  output logic [cell_width-1:0]      c_out_cell,
  input  logic                       c_ack
);
  localparam int IDXW = (size > 1) ? $clog2(size) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(size - 1);

  add_state_t                 state_r, next_state_s;
  logic [cell_width*size-1:0] col_r;
  logic [IDXW-1:0]            idx_r;
  logic [cell_width-1:0]      acc_r;
  logic                       out_ready_r;

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, sx, round_up;
    logic [7:0]  ea, eb;
    logic [26:0] xa, xb, x, y, lost;
    logic [9:0]  ex, ey, d, e;
    logic [27:0] s;
    logic [24:0] m;
    logic [31:0] res;
    ea    = a[30:23];
    eb    = b[30:23];
    a_nan = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (eb == 8'hFF) && (b[22:0] == 23'd0);
    xa    = {(ea != 8'd0), a[22:0], 3'b000};
    xb    = {(eb != 8'd0), b[22:0], 3'b000};
    res   = 32'h0000_0000;
    if (a_nan) begin
      res = a | 32'h0040_0000;
    end else if (b_nan) begin
      res = b | 32'h0040_0000;
    end else if (a_inf && b_inf && (a[31] != b[31])) begin
      res = 32'h7FC0_0000;
    end else if (a_inf) begin
      res = a;
    end else if (b_inf) begin
      res = b;
    end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      res = {a[31] & b[31], 31'd0};
    end else begin
      // x is the larger magnitude operand; subnormals use exponent 1.
      if (a[30:0] >= b[30:0]) begin
        x = xa; sx = a[31]; ex = {2'b00, (ea == 8'd0) ? 8'd1 : ea};
        y = xb;             ey = {2'b00, (eb == 8'd0) ? 8'd1 : eb};
      end else begin
        x = xb; sx = b[31]; ex = {2'b00, (eb == 8'd0) ? 8'd1 : eb};
        y = xa;             ey = {2'b00, (ea == 8'd0) ? 8'd1 : ea};
      end
      d = ex - ey;
      if (d >= 10'd27) begin
        y = {26'd0, |y};
      end else begin
        lost = y << (10'd27 - d);
        y    = (y >> d) | {26'd0, |lost};
      end
      s = (a[31] == b[31]) ? ({1'b0, x} + {1'b0, y}) : ({1'b0, x} - {1'b0, y});
      e = ex;
      if (s == 28'd0) begin
        res = 32'h0000_0000;
      end else begin
        if (s[27]) begin
          s = {1'b0, s[27:2], s[1] | s[0]};
          e = e + 10'd1;
        end else begin
          for (int i = 0; i < 26; i++) begin
            if (!s[26] && (e > 10'd1)) begin
              s = s << 1;
              e = e - 10'd1;
            end
          end
        end
        round_up = s[2] & (s[1] | s[0] | s[3]);
        m = {1'b0, s[26:3]} + {24'd0, round_up};
        if (m[24]) begin
          m = m >> 1;
          e = e + 10'd1;
        end
        if (e >= 10'd255) begin
          res = {sx, 8'hFF, 23'd0};
        end else begin
          res = {sx, (m[23] ? e[7:0] : 8'd0), m[22:0]};
        end
      end
    end
    return res;
  endfunction

  // Adder state register.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) state_r <= ADD_IDLE;
    else           state_r <= next_state_s;
  end

  // Adder next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ADD_IDLE: begin
        if (c_ready) next_state_s = (size == 1) ? ADD_OUT : ADD_RUN;
        else         next_state_s = ADD_IDLE;
      end
      ADD_RUN: begin
        if (idx_r == IDX_LAST) next_state_s = ADD_OUT;
        else                   next_state_s = ADD_RUN;
      end
      ADD_OUT: begin
        if (c_ack) next_state_s = ADD_IDLE;
        else       next_state_s = ADD_OUT;
      end
      default: next_state_s = ADD_IDLE;
    endcase
  end

  // Column latch, running accumulator and result-valid flag.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      col_r       <= '0;
      idx_r       <= '0;
      acc_r       <= '0;
      out_ready_r <= 1'b0;
    end else begin
      case (state_r)
        ADD_IDLE: begin
          if (c_ready) begin
            col_r <= c_col;
            acc_r <= c_col[cell_width-1:0];
            idx_r <= IDXW'(1);
          end
        end
        ADD_RUN: begin
          acc_r <= fp_add(acc_r, col_r[int'(idx_r)*cell_width +: cell_width]);
          idx_r <= idx_r + IDXW'(1);
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
      out_ready_r <= (next_state_s == ADD_OUT);
    end
  end

  assign c_out_ready = out_ready_r;
  assign c_out_cell  = acc_r;

endmodule

// File: rtl/column_sum_sequencer.sv
// Column-sum sequencer: latches a matrix, feeds each column through the single
// column_adder and collects the scalar results into out_sums.
module column_sum_sequencer
  import column_sum_sequencer_pkg::*;
#(
  parameter int size       = 4,
  parameter int cell_width = 32,
  parameter int width      = cell_width * size * size
) (
  input logic                   in_clk,
  input logic                   in_reset,
  column_sum_sequencer_if.slave bus
);
  localparam int COLW = (size > 1) ? $clog2(size) : 1;
  localparam logic [COLW-1:0] COL_LAST = COLW'(size - 1);

  seq_state_t                 state_r, next_state_s;
  logic [width-1:0]           matrix_r;
  logic [COLW-1:0]            col_r;
  logic [cell_width*size-1:0] sums_r;
  logic                       busy_r;
  logic                       ready_r;
  logic                       c_ready_s;
  logic                       c_ack_s;
  logic [cell_width*size-1:0] c_col_s;
  logic                       c_out_ready_s;
  logic [cell_width-1:0]      c_out_cell_s;

  assign c_col_s = matrix_r[cell_index(0, int'(col_r), size)*cell_width +: cell_width*size];

  column_adder #(
    .size       (size),
    .cell_width (cell_width)
  ) u_column_adder (
    .in_clk      (in_clk),
    .in_reset    (in_reset),
    .c_ready     (c_ready_s),
    .c_col       (c_col_s),
    .c_out_ready (c_out_ready_s),
    .c_out_cell  (c_out_cell_s),
    .c_ack       (c_ack_s)
  );

  // Sequencer state register.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) state_r <= IDLE;
    else           state_r <= next_state_s;
  end

  // Sequencer next-state and child handshake strobes.
  always_comb begin
    next_state_s = state_r;
    c_ready_s    = 1'b0;
    c_ack_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_ready) next_state_s = LOAD;
        else              next_state_s = IDLE;
      end
      LOAD: begin
        c_ready_s    = 1'b1;
        next_state_s = WAIT;
      end
      WAIT: begin
        if (c_out_ready_s) next_state_s = ACK;
        else               next_state_s = WAIT;
      end
      ACK: begin
        // Keep acknowledging until the child has visibly dropped its result.
        c_ack_s = 1'b1;
        if (!c_out_ready_s) next_state_s = (col_r == COL_LAST) ? DONE : LOAD;
        else                next_state_s = ACK;
      end
      DONE: begin
        if (bus.out_ack) next_state_s = IDLE;
        else             next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Matrix latch, column counter, result vector and registered status outputs.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      matrix_r <= '0;
      col_r    <= '0;
      sums_r   <= '0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_ready) begin
            matrix_r <= bus.in_matrix;
            col_r    <= '0;
            sums_r   <= '0;
          end
        end
        WAIT: begin
          if (c_out_ready_s) sums_r[int'(col_r)*cell_width +: cell_width] <= c_out_cell_s;
        end
        ACK: begin
          if (!c_out_ready_s && (col_r != COL_LAST)) col_r <= col_r + COLW'(1);
        end
        default: begin
          col_r <= col_r;
        end
      endcase
      busy_r  <= (next_state_s != IDLE);
      ready_r <= (next_state_s == DONE);
    end
  end

  assign bus.out_busy  = busy_r;
  assign bus.out_ready = ready_r;
  assign bus.out_sums  = sums_r;

endmodule

// File: tb/tb_column_sum_sequencer.sv
// Bench for column_sum_sequencer: real-arithmetic column-sum model checked every
// cycle a result is valid, plus directed handshake/reset scenarios with literals.
module tb_column_sum_sequencer;
  localparam int SZ = 4;
  localparam int CW = 32;
  localparam int SW = CW * SZ;
  localparam int MW = CW * SZ * SZ;

  localparam logic [31:0] F0  = 32'h0000_0000, F05 = 32'h3F00_0000, F1 = 32'h3F80_0000;
  localparam logic [31:0] F2  = 32'h4000_0000, F3  = 32'h4040_0000, F4 = 32'h4080_0000;
  localparam logic [31:0] F5  = 32'h40A0_0000, F6  = 32'h40C0_0000;
  localparam logic [31:0] FM1 = 32'hBF80_0000, FM2 = 32'hC000_0000;

  logic in_clk   = 1'b0;
  logic in_reset = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  logic [SW-1:0] exp_sums = '0;

  column_sum_sequencer_if #(.size(SZ), .cell_width(CW)) bus ();
  column_sum_sequencer_if #(.size(2), .cell_width(CW))  bus2 ();

  column_sum_sequencer #(.size(SZ), .cell_width(CW)) dut (
    .in_clk(in_clk), .in_reset(in_reset), .bus(bus)
  );
  column_sum_sequencer #(.size(2), .cell_width(CW)) dut2 (
    .in_clk(in_clk), .in_reset(in_reset), .bus(bus2)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic real to_real(input logic [31:0] b);
    real v;
    if (b[30:0] == 31'd0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(int'(b[30:23])) - 127.0));
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] to_bits(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0000_0000;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // Expected out_sums: each column summed in real arithmetic (vectors are exact).
  function automatic logic [SW-1:0] model_sums(input logic [MW-1:0] m);
    logic [SW-1:0] res;
    real s;
    res = '0;
    for (int c = 0; c < SZ; c++) begin
      s = 0.0;
      for (int r = 0; r < SZ; r++) s = s + to_real(m[(c*SZ + r)*CW +: CW]);
      res[c*CW +: CW] = to_bits(s);
    end
    return res;
  endfunction

  function automatic logic [127:0] col4(input logic [31:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  function automatic logic [MW-1:0] mat4(input logic [127:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic request(input logic [MW-1:0] m);
    bus.in_matrix = m;
    bus.in_ready  = 1'b1;
    step();
    bus.in_ready  = 1'b0;
    exp_sums      = model_sums(m);
    chk("accept_busy", SW'(bus.out_busy), SW'(1));
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.out_ready !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    chk(name, SW'(bus.out_ready), SW'(1));
  endtask

  task automatic ack_result();
    bus.out_ack = 1'b1;
    step();
    bus.out_ack = 1'b0;
    chk("ack_ready_low", SW'(bus.out_ready), '0);
    chk("ack_busy_low", SW'(bus.out_busy), '0);
  endtask

  // Whenever a result is presented it must equal the model for the accepted matrix.
  always @(negedge in_clk) begin
    if (!in_reset) begin
      chk("reset_outputs", {bus.out_sums[SW-1:2], bus.out_busy, bus.out_ready}, '0);
    end else if (bus.out_ready === 1'b1) begin
      chk("sums_model", bus.out_sums, exp_sums);
      chk("busy_with_ready", SW'(bus.out_busy), SW'(1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [MW-1:0] ma, mb, mc;
    logic [SW-1:0] lit_a, lit_b, lit_c;
    int n;
    ma    = mat4(col4(F1, F2, F3, F4), col4(F05, F05, F05, F05),
                 col4(F1, FM1, F0, F0), col4(F4, F4, FM1, F0));
    lit_a = {32'h40E0_0000, 32'h0000_0000, 32'h4000_0000, 32'h4120_0000};
    mb    = mat4(col4(F3, F4, F0, F0), col4(F2, F2, F2, F2),
                 col4(FM1, FM2, F0, F0), col4(F05, F1, F0, F0));
    lit_b = {32'h3FC0_0000, 32'hC040_0000, 32'h4100_0000, 32'h40E0_0000};
    mc    = mat4(col4(F5, F1, F1, F1), col4(F6, F1, F0, F0),
                 col4(F0, F0, F0, F0), col4(F1, F1, F1, F1));
    lit_c = {32'h4080_0000, 32'h0000_0000, 32'h40E0_0000, 32'h4100_0000};

    bus.in_matrix  = '0; bus.in_ready  = 1'b0; bus.out_ack  = 1'b0;
    bus2.in_matrix = '0; bus2.in_ready = 1'b0; bus2.out_ack = 1'b0;
    repeat (3) step();
    chk("rst_busy", SW'(bus.out_busy), '0);
    chk("rst_ready", SW'(bus.out_ready), '0);
    chk("rst_sums", bus.out_sums, '0);
    in_reset = 1'b1;
    step();

    // 2x2 instance: cols {1,2} and {3,4}.
    bus2.in_matrix = 128'h4080_0000_4040_0000_4000_0000_3F80_0000;
    bus2.in_ready  = 1'b1;
    step();
    bus2.in_ready  = 1'b0;
    n = 0;
    while (bus2.out_ready !== 1'b1 && n < 1000) begin step(); n++; end
    chk("t1_ready", SW'(bus2.out_ready), SW'(1));
    chk("t1_sums", SW'(bus2.out_sums), SW'(64'h40E0_0000_4040_0000));
    bus2.out_ack = 1'b1;
    step();
    bus2.out_ack = 1'b0;
    chk("t1_ack_ready_low", SW'(bus2.out_ready), '0);

    // Mixed columns, including 1.0 + -1.0 cancelling to +0.
    request(ma);
    wait_ready("ta_ready");
    chk("ta_literal", bus.out_sums, lit_a);
    chk("t2_cancel_cell", SW'(bus.out_sums[2*CW +: CW]), '0);
    ack_result();

    // All-zero matrix.
    request('0);
    wait_ready("t2_ready");
    chk("t2_zero", bus.out_sums, '0);
    ack_result();

    // Result held in DONE while the request side toggles.
    request(mb);
    wait_ready("t3_ready");
    for (int i = 0; i < 20; i++) begin
      bus.in_ready  = i[0];
      bus.in_matrix = ~mb ^ MW'(i);
      step();
      chk("t3_hold_ready", SW'(bus.out_ready), SW'(1));
      chk("t3_hold_sums", bus.out_sums, lit_b);
    end
    bus.in_ready = 1'b0;
    ack_result();
    repeat (3) step();
    chk("t3_no_queue", SW'(bus.out_busy), '0);

    // Request during column 0 is ignored.
    request(ma);
    step();
    bus.in_matrix = mb;
    bus.in_ready  = 1'b1;
    step();
    bus.in_ready  = 1'b0;
    chk("t4_busy", SW'(bus.out_busy), SW'(1));
    wait_ready("t4_ready");
    chk("t4_first_matrix", bus.out_sums, lit_a);
    ack_result();

    // Reset while column 1 is in flight.
    request(mb);
    n = 0;
    while (bus.out_sums[CW-1:0] === 32'h0 && n < 1000) begin step(); n++; end
    chk("t5_col0_written", SW'(bus.out_sums[CW-1:0]), SW'(32'h40E0_0000));
    step();
    step();
    #2;
    in_reset = 1'b0;
    #1;
    chk("t5_reset_busy", SW'(bus.out_busy), '0);
    chk("t5_reset_ready", SW'(bus.out_ready), '0);
    chk("t5_reset_sums", bus.out_sums, '0);
    step();
    step();
    in_reset = 1'b1;
    step();
    chk("t5_idle_after", SW'(bus.out_busy), '0);
    request(mc);
    wait_ready("t5_ready");
    chk("t5_literal", bus.out_sums, lit_c);
    ack_result();

    // out_ack wins over a simultaneous in_ready in DONE.
    request(ma);
    wait_ready("t6_ready");
    bus.in_matrix = mc;
    bus.out_ack   = 1'b1;
    bus.in_ready  = 1'b1;
    step();
    bus.out_ack   = 1'b0;
    bus.in_ready  = 1'b0;
    chk("t6_not_accepted", SW'(bus.out_busy), '0);
    chk("t6_ready_low", SW'(bus.out_ready), '0);
    request(mc);
    wait_ready("t6_ready2");
    chk("t6_literal", bus.out_sums, lit_c);
    ack_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
